pu_stream: RTL

- Parametrised, streaming successor to the fixed 4-lane processing unit: LANES-wide signed fixed-point multiply, adder-tree reduction, multi-beat accumulation and selectable activation.
- Uses a valid/ready handshake on input and output, and stalls the whole pipeline under backpressure.
- Sits between the neuron-input sequencer and the result buffer.
- Computes one dot product per packet; a packet is one or more beats, terminated by in_last.

---
 rtl/pu_stream_if.sv | 28 ++
 rtl/pu_stream.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pu_stream_if.sv
// pu_stream_if: streaming handshake bundle for pu_stream.
//   in_valid/in_ready/in_last/act_vec/wgt_vec/relu_en : beat channel (producer -> pu_stream)
//   out_valid/out_ready/out_data                       : result channel (pu_stream -> consumer)
// master = producer/consumer side (testbench, sequencer), slave = pu_stream.
interface pu_stream_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [LANES*WIDTH-1:0]   act_vec;
  logic [LANES*WIDTH-1:0]   wgt_vec;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;

  modport master (
    output in_valid, in_last, act_vec, wgt_vec, relu_en, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_last, act_vec, wgt_vec, relu_en, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pu_stream.sv
// pu_stream: LANES-wide signed fixed-point dot product per packet.
//   clk, rst : rising-edge clock, async active-high reset
//   s        : pu_stream_if.slave (beat in, result out, valid/ready both sides)
//   busy     : any stage valid, result pending, or a packet open in the accumulator
// Pipeline: S0 input regs -> S1 per-lane multiply/shift/saturate -> S2 adder tree
//           -> S3 accumulate, saturate, optional ReLU, result register.
// The whole pipeline freezes while a last beat sits in S2 behind an unconsumed result.

// Per-lane Q-format multiply: full-width product, floor shift by FRAC, saturate.
module pu_lane_mul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shr;
  logic [PW-WIDTH:0]       top;
  logic [WIDTH-1:0]        sat;

  always_comb begin
    prod = PW'($signed(a)) * PW'($signed(w));
    shr  = prod >>> FRAC;
    top  = shr[PW-1:WIDTH-1];
    // In range iff every bit above the result sign bit matches it.
    if (top == '0 || &top) sat = shr[WIDTH-1:0];
    else if (shr[PW-1])    sat = {1'b1, {(WIDTH-1){1'b0}}};
    else                   sat = {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)     p <= '0;
    else if (en) p <= sat;
endmodule

module pu_stream #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 40
) (
  input  logic          clk,
  input  logic          rst,
  pu_stream_if.slave    s,
  output logic          busy
);
  localparam int STAGES = 3;
  localparam int SUM_W  = WIDTH + $clog2(LANES);

  logic                              rdy_q;
  logic                              stall;
  logic                              in_fire;
  logic [STAGES:1]                   vld_pipe, lst_pipe, rlu_pipe;
  logic [LANES-1:0][WIDTH-1:0]       act_q, wgt_q, prod_q;
  logic signed [SUM_W-1:0]           sum_c, sum_q;
  logic signed [ACC_W-1:0]           acc, acc_next;
  logic [ACC_W-WIDTH:0]              acc_top;
  logic [WIDTH-1:0]                  res_sat, res;
  logic                              pkt_open;
  logic                              ov_q;
  logic [WIDTH-1:0]                  od_q;

  // Only a last beat in S2 can collide with a pending result; others just accumulate.
  assign stall      = ov_q && !s.out_ready && vld_pipe[3] && lst_pipe[3];
  assign s.in_ready = rdy_q && !stall;
  assign in_fire    = s.in_valid && s.in_ready;
  assign s.out_valid = ov_q;
  assign s.out_data  = od_q;
  assign busy = |vld_pipe | ov_q | pkt_open;

  // in_ready comes up on the first edge after reset release.
  always_ff @(posedge clk or posedge rst)
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;

  // S0 input capture plus valid/last/relu shift registers for all stages.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
      rlu_pipe <= '0;
      act_q    <= '0;
      wgt_q    <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
      lst_pipe <= {lst_pipe[STAGES-1:1], s.in_last};
      rlu_pipe <= {rlu_pipe[STAGES-1:1], s.relu_en};
      act_q    <= s.act_vec;
      wgt_q    <= s.wgt_vec;
    end

  // S1: per-lane multipliers.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pu_lane_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (!stall),
      .a   (act_q[i]),
      .w   (wgt_q[i]),
      .p   (prod_q[i])
    );
  end

  // S2: reduction at WIDTH+log2(LANES) bits cannot overflow.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++)
      sum_c = sum_c + SUM_W'($signed(prod_q[i]));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)         sum_q <= '0;
    else if (!stall) sum_q <= sum_c;

  // S3: accumulate, then saturate/activate on the last beat.
  always_comb begin
    acc_next = acc + ACC_W'(sum_q);
    acc_top  = acc_next[ACC_W-1:WIDTH-1];
    if (acc_top == '0 || &acc_top) res_sat = acc_next[WIDTH-1:0];
    else if (acc_next[ACC_W-1])    res_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else                           res_sat = {1'b0, {(WIDTH-1){1'b1}}};
    res = (rlu_pipe[3] && res_sat[WIDTH-1]) ? '0 : res_sat;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc      <= '0;
      pkt_open <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
    end else begin
      if (ov_q && s.out_ready) ov_q <= 1'b0;
      // A load on the same edge as a consume wins, giving back-to-back results.
      if (!stall && vld_pipe[3]) begin
        if (lst_pipe[3]) begin
          od_q     <= res;
          ov_q     <= 1'b1;
          acc      <= '0;
          pkt_open <= 1'b0;
        end else begin
          acc      <= acc_next;
          pkt_open <= 1'b1;
        end
      end
    end
endmodule
